wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: M0 (read-only fetch) and M1 (data) share one bus.
// Ownership is registered and held for the owner's whole cyc window; everything else is pass-through.
module wb_arbiter #(
  parameter bit G_ROUND_ROBIN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [15:0] m0_addr_i,
  output logic        m0_stall_o,
  output logic        m0_ack_o,
  output logic [15:0] m0_data_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m1_wrdat_i,
  output logic        m1_stall_o,
  output logic        m1_ack_o,
  output logic [15:0] m1_data_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_addr_o,
  output logic [15:0] wb_wrdat_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic [15:0] wb_rddat_i,

  output logic [1:0]  dbg_state_o
);

  // Handshake: a master transfer happens on a cycle where stb=1 and stall=0;
  // a response is accepted on the cycle ack=1, and only while the owner's cyc=1.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_last_m1;
  logic   w_release_m0;
  logic   w_release_m1;
  logic   w_tie_pick_m1;

  assign w_release_m0  = (r_state == ST_GRANT0) && !m0_cyc_i;
  assign w_release_m1  = (r_state == ST_GRANT1) && !m1_cyc_i;
  // On a tie, round-robin serves whoever was not served last; fixed mode always favours M1.
  assign w_tie_pick_m1 = G_ROUND_ROBIN ? !r_last_m1 : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_release_m0) begin
        r_last_m1 <= 1'b0;
      end else if (w_release_m1) begin
        r_last_m1 <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next_state = w_tie_pick_m1 ? ST_GRANT1 : ST_GRANT0;
        end else if (m0_cyc_i) begin
          w_next_state = ST_GRANT0;
        end else if (m1_cyc_i) begin
          w_next_state = ST_GRANT1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (!m0_cyc_i) begin
          w_next_state = m1_cyc_i ? ST_GRANT1 : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (!m1_cyc_i) begin
          w_next_state = m0_cyc_i ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Owner's signals pass straight through; an owner that dropped cyc sees no ack.
  always_comb begin
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_addr_o  = 16'h0000;
    wb_wrdat_o = 16'h0000;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    case (r_state)
      ST_GRANT0: begin
        wb_cyc_o   = m0_cyc_i;
        wb_stb_o   = m0_stb_i;
        wb_addr_o  = m0_addr_i;
        m0_stall_o = wb_stall_i;
        m0_ack_o   = wb_ack_i && m0_cyc_i;
      end
      ST_GRANT1: begin
        wb_cyc_o   = m1_cyc_i;
        wb_stb_o   = m1_stb_i;
        wb_we_o    = m1_we_i;
        wb_addr_o  = m1_addr_i;
        wb_wrdat_o = m1_wrdat_i;
        m1_stall_o = wb_stall_i;
        m1_ack_o   = wb_ack_i && m1_cyc_i;
      end
      default: begin
      end
    endcase
  end

  assign m0_data_o   = wb_rddat_i;
  assign m1_data_o   = wb_rddat_i;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a round-robin instance and a fixed-priority instance on shared stimulus.
module tb_wb_arbiter;

  localparam int W = 78;
  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_0 = 2'd1;
  localparam logic [1:0] S_1 = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_fp;
  logic m0_cyc, m0_stb;
  logic [15:0] m0_addr;
  logic m1_cyc, m1_stb, m1_we;
  logic [15:0] m1_addr, m1_wrdat;
  logic wb_stall, wb_ack;
  logic [15:0] wb_rddat;

  logic m0_stall, m0_ack, m1_stall, m1_ack;
  logic [15:0] m0_data, m1_data;
  logic wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_addr, wb_wrdat;
  logic [1:0] rr_state;

  logic fp_m0_stall, fp_m0_ack, fp_m1_stall, fp_m1_ack;
  logic [15:0] fp_m0_data, fp_m1_data;
  logic fp_wb_cyc, fp_wb_stb, fp_wb_we;
  logic [15:0] fp_wb_addr, fp_wb_wrdat;
  logic [1:0] fp_state;

  wb_arbiter #(.G_ROUND_ROBIN(1'b1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr),
    .m0_stall_o(m0_stall), .m0_ack_o(m0_ack), .m0_data_o(m0_data),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_addr_i(m1_addr), .m1_wrdat_i(m1_wrdat),
    .m1_stall_o(m1_stall), .m1_ack_o(m1_ack), .m1_data_o(m1_data),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_addr_o(wb_addr), .wb_wrdat_o(wb_wrdat),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_rddat_i(wb_rddat),
    .dbg_state_o(rr_state)
  );

  wb_arbiter #(.G_ROUND_ROBIN(1'b0)) u_fp (
    .clk_i(clk), .rst_i(rst_fp),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr),
    .m0_stall_o(fp_m0_stall), .m0_ack_o(fp_m0_ack), .m0_data_o(fp_m0_data),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_addr_i(m1_addr), .m1_wrdat_i(m1_wrdat),
    .m1_stall_o(fp_m1_stall), .m1_ack_o(fp_m1_ack), .m1_data_o(fp_m1_data),
    .wb_cyc_o(fp_wb_cyc), .wb_stb_o(fp_wb_stb), .wb_we_o(fp_wb_we),
    .wb_addr_o(fp_wb_addr), .wb_wrdat_o(fp_wb_wrdat),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_rddat_i(wb_rddat),
    .dbg_state_o(fp_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] obs;
  assign obs = {rr_state, wb_cyc, wb_stb, wb_we, wb_addr, wb_wrdat,
                m0_stall, m0_ack, m0_data, m1_stall, m1_ack, m1_data,
                fp_state, fp_m0_stall, fp_m1_stall, fp_m1_ack};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, obs, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Expected outputs for this cycle, given the state the DUT should hold and the applied inputs.
  task automatic chk(input string nm, input logic [1:0] es, input logic [1:0] efs);
    logic g0, g1, f0, f1;
    logic [W-1:0] e;
    g0 = (es == S_0);
    g1 = (es == S_1);
    f0 = (efs == S_0);
    f1 = (efs == S_1);
    e = {es,
         g0 ? m0_cyc : (g1 ? m1_cyc : 1'b0),
         g0 ? m0_stb : (g1 ? m1_stb : 1'b0),
         g1 ? m1_we : 1'b0,
         g0 ? m0_addr : (g1 ? m1_addr : 16'h0000),
         g1 ? m1_wrdat : 16'h0000,
         g0 ? wb_stall : 1'b1,
         g0 & m0_cyc & wb_ack,
         wb_rddat,
         g1 ? wb_stall : 1'b1,
         g1 & m1_cyc & wb_ack,
         wb_rddat,
         efs,
         f0 ? wb_stall : 1'b1,
         f1 ? wb_stall : 1'b1,
         f1 & m1_cyc & wb_ack};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic both(input logic c);
    m0_cyc = c; m0_stb = c;
    m1_cyc = c; m1_stb = c;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rst_fp = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_addr = 16'h0000;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    m1_addr = 16'h0000; m1_wrdat = 16'h0000;
    wb_stall = 1'b0; wb_ack = 1'b1; wb_rddat = 16'h5A5A;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle_ack_ignored", S_I, S_I);
    rst = 1'b0; wb_ack = 1'b0;

    // single M0 read
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 16'h0010;
    chk("m0_req_latency", S_I, S_I);
    chk("m0_grant", S_0, S_I);
    m0_stb = 1'b0; wb_ack = 1'b1; wb_rddat = 16'hBEEF;
    chk("m0_ack_beef", S_0, S_I);
    m0_cyc = 1'b0; wb_ack = 1'b0;
    chk("m0_release", S_0, S_I);
    chk("m0_back_idle", S_I, S_I);

    // round-robin ties from fresh reset
    rst = 1'b1;
    chk("rst_pulse", S_I, S_I);
    rst = 1'b0;
    m0_addr = 16'h0100; m1_addr = 16'h0200; m1_wrdat = 16'h7777;
    both(1'b1);
    chk("tie1_idle", S_I, S_I);
    chk("tie1_m0_first", S_0, S_I);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    chk("tie1_m0_release", S_0, S_I);
    chk("handover_m1", S_1, S_I);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    chk("m1_release", S_1, S_I);
    both(1'b1);
    chk("tie2_idle", S_I, S_I);
    chk("tie2_m0", S_0, S_I);
    both(1'b0);
    chk("tie2_release", S_0, S_I);
    both(1'b1);
    chk("tie3_idle", S_I, S_I);
    chk("tie3_m1", S_1, S_I);
    both(1'b0);
    chk("tie3_release", S_1, S_I);
    chk("idle_after_ties", S_I, S_I);

    // stalled M1 write; M0 strobes without cyc and must not leak
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_addr = 16'h8000; m1_wrdat = 16'h1234;
    m0_stb = 1'b1; m0_addr = 16'hDEAD;
    chk("wr_req", S_I, S_I);
    wb_stall = 1'b1;
    chk("wr_stall1", S_1, S_I);
    chk("wr_stall2", S_1, S_I);
    chk("wr_stall3", S_1, S_I);
    wb_stall = 1'b0;
    chk("wr_accept", S_1, S_I);
    m1_stb = 1'b0; wb_ack = 1'b1; wb_rddat = 16'h0F0F;
    chk("wr_ack_m1_only", S_1, S_I);
    wb_ack = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0; m0_stb = 1'b0;
    chk("wr_release", S_1, S_I);

    // M0 abort with late ack while M1 waits
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 16'h0030;
    chk("ab_req", S_I, S_I);
    chk("ab_grant0", S_0, S_I);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 16'h0040;
    chk("ab_no_preempt", S_0, S_I);
    m0_cyc = 1'b0; m0_stb = 1'b0; wb_ack = 1'b1; wb_rddat = 16'hAAAA;
    chk("ab_drop_late_ack", S_0, S_I);
    wb_ack = 1'b0;
    chk("ab_grant1", S_1, S_I);

    // reset during M1 ownership with ack arriving around it
    rst = 1'b1; wb_ack = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_no_ack", S_I, S_I);
    wb_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    chk("regrant_m1_after_rst", S_1, S_I);

    // fixed-priority instance; round-robin instance held in reset
    rst = 1'b1; rst_fp = 1'b0;
    chk("fp_idle", S_I, S_I);
    both(1'b1);
    chk("fp_tie1", S_I, S_I);
    chk("fp_tie1_m1", S_I, S_1);
    both(1'b0);
    chk("fp_release1", S_I, S_1);
    both(1'b1);
    chk("fp_tie2", S_I, S_I);
    chk("fp_tie2_m1", S_I, S_1);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    chk("fp_release2", S_I, S_1);
    chk("fp_handover_m0", S_I, S_0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    chk("fp_m0_release", S_I, S_0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
